// File: rtl/ibex_axi_pkg.sv
// Shared AXI4 encodings and FSM states for the Ibex
// instruction/data memory responder.
package ibex_axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage

// File: rtl/ibex_axi_dp_ram.sv
// Simple dual-port RAM: one write port, one synchronous
// read port whose output holds while the read is idle.
module ibex_axi_dp_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Read-first: a same-cycle write is seen on the next read.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/ibex_axi_imem_slave.sv
// AXI4 read-only burst responder backed by a preloadable RAM;
// serves one AR burst at a time at one beat per cycle.
module ibex_axi_imem_slave
  import ibex_axi_pkg::*;
#(
  parameter logic [31:0] C_S_AXI_BASE_ADDR   = 32'h00000000,
  parameter int          C_S_AXI_ID_WIDTH    = 1,
  parameter int          C_S_AXI_ADDR_WIDTH  = 32,
  parameter int          C_S_AXI_DATA_WIDTH  = 32,
  parameter int          C_MEM_DEPTH         = 4096
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [7:0]                      s00_axi_arlen,
  input  logic [2:0]                      s00_axi_arsize,
  input  logic [1:0]                      s00_axi_arburst,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_rid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rlast,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic                            load_we,
  input  logic [$clog2(C_MEM_DEPTH)-1:0]  load_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   load_data
);

  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int IW       = C_S_AXI_ID_WIDTH;
  localparam int LP_BYTES = C_S_AXI_DATA_WIDTH / 8;
  localparam int LP_SHIFT = $clog2(LP_BYTES);
  localparam int LP_MAW   = $clog2(C_MEM_DEPTH);
  localparam logic [2:0]  LP_SZ_MAX = 3'(LP_SHIFT);
  localparam logic [AW-1:0] LP_BASE = AW'(C_S_AXI_BASE_ADDR);
  localparam logic [AW:0] LP_LIMIT =
    (AW+1)'(C_MEM_DEPTH) << LP_SHIFT;

  state_e          r_state, w_next;
  logic            r_rdy_en;
  logic [IW-1:0]   r_id;
  logic [AW-1:0]   r_addr;
  logic [7:0]      r_len;
  logic [7:0]      r_cnt;
  logic [2:0]      r_size;
  logic [1:0]      r_burst;

  logic            w_ar_hs, w_r_hs, w_re;
  logic [AW-1:0]   w_step, w_addr_nx, w_off;
  logic [LP_MAW-1:0] w_raddr;
  logic            w_slverr, w_decerr;
  resp_e           w_resp;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_ram_q;

  function automatic logic [LP_MAW-1:0] f_idx(
    input logic [AW-1:0] a
  );
    return LP_MAW'((a - LP_BASE) >> LP_SHIFT);
  endfunction

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) r_state <= ST_IDLE;
    else                  r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    s00_axi_arready = 1'b0;
    s00_axi_rvalid  = 1'b0;
    s00_axi_rlast   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        s00_axi_arready = r_rdy_en;
        if (s00_axi_arvalid && r_rdy_en) w_next = ST_BURST;
      end
      ST_BURST: begin
        s00_axi_rvalid = 1'b1;
        s00_axi_rlast  = (r_cnt == r_len);
        if (s00_axi_rready && s00_axi_rlast) w_next = ST_IDLE;
      end
    endcase
  end

  assign w_ar_hs = s00_axi_arvalid & s00_axi_arready;
  assign w_r_hs  = s00_axi_rvalid & s00_axi_rready;

  assign w_step    = AW'(1) << r_size;
  assign w_addr_nx = (r_burst == BURST_INCR) ? r_addr + w_step
                                             : r_addr;

  // arready stays low until the first clock after reset release.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_rdy_en <= 1'b0;
      r_id     <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_size   <= '0;
      r_burst  <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_ar_hs) begin
        r_id    <= s00_axi_arid;
        r_addr  <= s00_axi_araddr;
        r_len   <= s00_axi_arlen;
        r_size  <= s00_axi_arsize;
        r_burst <= s00_axi_arburst;
        r_cnt   <= '0;
      end else if (w_r_hs && !s00_axi_rlast) begin
        r_addr <= w_addr_nx;
        r_cnt  <= r_cnt + 8'd1;
      end
    end
  end

  assign w_re    = w_ar_hs | (w_r_hs & ~s00_axi_rlast);
  assign w_raddr = (r_state == ST_IDLE) ? f_idx(s00_axi_araddr)
                                        : f_idx(w_addr_nx);

  assign w_off    = r_addr - LP_BASE;
  assign w_slverr = (r_burst == BURST_WRAP) ||
                    (r_burst == BURST_RSVD) ||
                    (r_size > LP_SZ_MAX);
  assign w_decerr = (r_addr < LP_BASE) ||
                    ({1'b0, w_off} >= LP_LIMIT);

  always_comb begin
    w_resp = RESP_OKAY;
    if (w_slverr)      w_resp = RESP_SLVERR;
    else if (w_decerr) w_resp = RESP_DECERR;
  end

  assign s00_axi_rresp = s00_axi_rvalid ? w_resp : RESP_OKAY;
  assign s00_axi_rid   = s00_axi_rvalid ? r_id : '0;
  assign s00_axi_rdata =
    (s00_axi_rvalid && w_resp == RESP_OKAY) ? w_ram_q : '0;

  ibex_axi_dp_ram #(
    .DW    (C_S_AXI_DATA_WIDTH),
    .DEPTH (C_MEM_DEPTH),
    .AW    (LP_MAW)
  ) u_ram (
    .clk     (s00_axi_aclk),
    .i_we    (load_we),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_q)
  );

endmodule

// File: doc/ibex_axi_imem_slave.md
# ibex_axi_imem_slave

AXI4 read-only responder (burst-capable instruction/data ROM) that serves the Ibex wrapper's AXI4 master read channel in simulation and on FPGA. Accepts one AR burst at a time, returns beats from an internal 1R1W memory at one beat per cycle, and flags unsupported or out-of-range accesses. A side-band load port preloads program images.

## Interface
- C_S_AXI_BASE_ADDR, 32'h00000000, byte address mapped to word 0
- C_S_AXI_ID_WIDTH, 1, ARID/RID width
- C_S_AXI_ADDR_WIDTH, 32, address width
- C_S_AXI_DATA_WIDTH, 32, data width (32 or 64)
- C_MEM_DEPTH, 4096, words; power of two
- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  asynchronous active-low reset
- s00_axi_arid  in  ID_WIDTH  burst ID
- s00_axi_araddr  in  ADDR_WIDTH  start byte address
- s00_axi_arlen  in  8  beats-1
- s00_axi_arsize  in  3  log2 bytes/beat
- s00_axi_arburst  in  2  burst type
- s00_axi_arvalid  in  1  address valid
- s00_axi_arready  out  1  address ready
- s00_axi_rid  out  ID_WIDTH  echoed ARID
- s00_axi_rdata  out  DATA_WIDTH  read data
- s00_axi_rresp  out  2  beat response
- s00_axi_rlast  out  1  final beat
- s00_axi_rvalid  out  1  data valid
- s00_axi_rready  in  1  data ready
- load_we  in  1  preload write enable
- load_addr  in  log2(C_MEM_DEPTH)  preload word index
- load_data  in  DATA_WIDTH  preload word

## Operation
- FSM: IDLE, BURST. arready = (state==IDLE). AR handshake in IDLE latches id, addr, len, size, burst; beat counter = 0; RAM reads beat 0; -> BURST.
- BURST: rvalid=1. On R handshake: if rlast -> IDLE; else addr advances, counter++, RAM reads next beat same cycle. No handshake: all R outputs hold stable.
- rlast = (counter == latched len).
- Next address: INCR addr + (1<<size); FIXED unchanged. Word index = (addr - BASE) >> log2(DATA_WIDTH/8), truncated to log2(DEPTH) bits after range check.
- Per-beat response: OKAY(00) normally; SLVERR(10) if burst==WRAP/reserved or (1<<size) > DATA_WIDTH/8; DECERR(11) if addr < BASE or offset >= DEPTH*bytes. Error beats drive rdata=0 but still complete arlen+1 beats.
- Narrow beats return the full word; unused lanes are not masked.
- Load port writes RAM on any cycle, independent of FSM. Same-cycle load and read of one word: read returns old data.

## Timing
- Reset (async assert, sync release): state IDLE, arready 0 while reset asserted, 1 from first clock after release; rvalid 0, rlast 0, rresp 00, rid 0, rdata 0.
- Latency: AR handshake at edge T -> rvalid, beat 0 at T+1. Back-to-back beats with rready=1: one per cycle; burst of N beats occupies N cycles plus return to IDLE.
- After last beat handshake at edge T, arready=1 at T+1 (one idle cycle between bursts).
- Reset mid-burst: burst discarded, outputs to reset values; RAM contents retained.
- Beat counter 8 bits; arlen=255 gives 256 beats, no wrap. Address counter wraps at 2^ADDR_WIDTH (then DECERR).

## Structure
- Shared ibex_axi_pkg: burst encodings (FIXED/INCR/WRAP), response codes (OKAY/EXOKAY/SLVERR/DECERR), FSM state enum.
- Sub-module ibex_axi_dp_ram: 1 write port (load), 1 synchronous read port with read enable, output holds when not enabled; FPGA BRAM-inferable.

## Test plan
- Preload words 0..15 = 0x1000+i; AR INCR addr=BASE, len=3, size=2 -> rdata 0x1000..0x1003, OKAY, rlast on 4th beat, 4 consecutive cycles.
- Same burst with rready toggled 1/0 -> each beat held stable while stalled, order preserved, no beat dropped.
- FIXED, addr=BASE+8, len=2 -> three beats of 0x1002.
- WRAP len=3 -> four beats SLVERR, rdata 0, rlast on 4th; next INCR burst returns OKAY.
- INCR starting at last word, len=1 -> beat 0 OKAY with word DEPTH-1, beat 1 DECERR rdata 0.
- Assert aresetn low during beat 2 of len=7 burst -> rvalid 0 immediately; after release arready=1, new burst returns correct data.
